frog_game_ctrl: RTL and testbench

- Game-state controller sitting directly downstream of the frog datapath.
- Consumes the frog's per-life outcome strobes (ReachedFinish, is_dead_delayed) and the finish-slot hits (OnFinish).
- Produces FrogFinished back to the frog, plus lives, score, level, a per-life countdown and the time_up death request.
- Also gates play via game_active, which the top level ORs into the frog's reset.

---
 rtl/frog_pkg.sv | 20 ++
 rtl/frog_game_ctrl_countdown.sv | 30 +++
 rtl/frog_game_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_frog_game_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frog_pkg.sv
// rtl/frog_pkg.sv - shared types and constants for the frog game-state controller
package frog_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        PLAY        = 3'd1,
        LEVEL_CLEAR = 3'd2,
        GAME_OVER   = 3'd3
    } game_state_t;

    localparam int                   NUM_SLOTS         = 5;
    localparam logic [NUM_SLOTS-1:0] SLOT_ALL          = 5'b11111;
    localparam logic [7:0]           START_KEY_DEFAULT = 8'h28;

    // Isolates the lowest set bit; zero in gives zero out.
    function automatic logic [NUM_SLOTS-1:0] lowest_set(input logic [NUM_SLOTS-1:0] v);
        return v & (~v + 1'b1);
    endfunction

endpackage

// File: rtl/frog_game_ctrl_countdown.sv
// rtl/frog_game_ctrl_countdown.sv - loadable frame down-counter with zero flag
module frame_countdown #(
    parameter int W = 11
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         zero_o
);

    logic [W-1:0] count_q;

    // Load wins over enable; the count sticks at zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/frog_game_ctrl.sv
// rtl/frog_game_ctrl.sv - lives/score/level/timer state machine downstream of the frog datapath
module frog_game_ctrl
    import frog_pkg::*;
#(
    parameter int         LIVES_INIT   = 3,
    parameter int         TIME_FRAMES  = 1800,
    parameter int         CLEAR_FRAMES = 120,
    parameter int         FINISH_PTS   = 50,
    parameter int         LEVEL_PTS    = 1000,
    parameter int         SCORE_MAX    = 9999,
    parameter logic [7:0] START_KEY    = START_KEY_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk_rising_edge,
    input  logic [7:0]  keycode,
    input  logic        is_dead_delayed,
    input  logic        ReachedFinish,
    input  logic [4:0]  OnFinish,
    output logic [4:0]  FrogFinished,
    output logic [2:0]  lives,
    output logic [13:0] score,
    output logic [2:0]  level,
    output logic [10:0] time_left,
    output logic        time_up,
    output logic        game_active,
    output logic        game_over,
    output logic [2:0]  state
);

    localparam int          HOLD_W     = $clog2(CLEAR_FRAMES + 1);
    localparam logic [10:0] TL_INIT    = 11'(TIME_FRAMES);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(CLEAR_FRAMES);
    localparam logic [2:0]  LIVES_W    = 3'(LIVES_INIT);
    localparam logic [14:0] FINISH_W   = 15'(FINISH_PTS);
    localparam logic [14:0] LEVEL_W    = 15'(LEVEL_PTS);
    localparam logic [14:0] SCORE_MAX_W = 15'(SCORE_MAX);

    game_state_t state_q;
    logic [7:0]  last_key_q;
    logic [4:0]  slot_latch_q;
    logic [4:0]  finished_q;
    logic [2:0]  lives_q;
    logic [2:0]  level_q;
    logic [13:0] score_q;
    logic        time_up_q;
    logic        game_active_q;

    logic [10:0]       tl_count;
    logic              tl_zero;
    logic [HOLD_W-1:0] hold_count;
    logic              hold_zero;

    logic        start_ev, init_ev;
    logic        play_frame, death, finish, tick;
    logic        lc_frame, clear_done;
    logic [4:0]  latch_now, finished_next;
    logic        all_filled;
    logic [14:0] score_add, score_sum;
    logic [13:0] score_next;
    logic        tl_load, tl_en, hold_load, hold_en;

    always_comb begin
        start_ev   = (keycode == START_KEY) && (last_key_q != START_KEY);
        init_ev    = start_ev && ((state_q == IDLE) || (state_q == GAME_OVER));
        play_frame = (state_q == PLAY) && frame_clk_rising_edge;
        death      = play_frame && is_dead_delayed;
        finish     = play_frame && !is_dead_delayed && ReachedFinish;
        tick       = play_frame && !is_dead_delayed && !ReachedFinish;
        lc_frame   = (state_q == LEVEL_CLEAR) && frame_clk_rising_edge;
        clear_done = lc_frame && (hold_count == HOLD_W'(1));

        // Include this cycle's overlap so a slot hit on the frame-edge cycle itself still counts.
        latch_now     = slot_latch_q | (ReachedFinish ? (OnFinish & ~finished_q) : 5'b0);
        finished_next = finished_q | lowest_set(latch_now);
        all_filled    = (finished_next == SLOT_ALL);

        score_add = '0;
        if (latch_now != 5'b0) begin
            score_add = FINISH_W + 15'(tl_count >> 4);
        end
        if (all_filled) begin
            score_add = score_add + LEVEL_W;
        end
        score_sum  = {1'b0, score_q} + score_add;
        score_next = (score_sum > SCORE_MAX_W) ? SCORE_MAX_W[13:0] : score_sum[13:0];

        tl_load   = init_ev || death || finish || clear_done;
        tl_en     = tick;
        hold_load = finish && all_filled;
        hold_en   = lc_frame && !hold_zero;
    end

    frame_countdown #(.W(11)) u_time_left (
        .clk_i      (Clk),
        .rst_ni     (Reset_n),
        .load_i     (tl_load),
        .load_val_i (TL_INIT),
        .en_i       (tl_en),
        .count_o    (tl_count),
        .zero_o     (tl_zero)
    );

    frame_countdown #(.W(HOLD_W)) u_clear_hold (
        .clk_i      (Clk),
        .rst_ni     (Reset_n),
        .load_i     (hold_load),
        .load_val_i (HOLD_INIT),
        .en_i       (hold_en),
        .count_o    (hold_count),
        .zero_o     (hold_zero)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= IDLE;
            last_key_q    <= '0;
            slot_latch_q  <= '0;
            finished_q    <= '0;
            lives_q       <= '0;
            level_q       <= '0;
            score_q       <= '0;
            time_up_q     <= 1'b0;
            game_active_q <= 1'b0;
        end else begin
            last_key_q    <= keycode;
            game_active_q <= (state_q == PLAY);
            case (state_q)
                IDLE, GAME_OVER: begin
                    if (init_ev) begin
                        lives_q      <= LIVES_W;
                        score_q      <= '0;
                        level_q      <= '0;
                        finished_q   <= '0;
                        time_up_q    <= 1'b0;
                        slot_latch_q <= '0;
                        state_q      <= PLAY;
                    end
                end
                PLAY: begin
                    if (death) begin
                        lives_q      <= lives_q - 1'b1;
                        time_up_q    <= 1'b0;
                        slot_latch_q <= '0;
                        if (lives_q == 3'd1) begin
                            state_q <= GAME_OVER;
                        end
                    end else if (finish) begin
                        slot_latch_q <= '0;
                        finished_q   <= finished_next;
                        score_q      <= score_next;
                        if (all_filled) begin
                            state_q <= LEVEL_CLEAR;
                        end
                    end else begin
                        slot_latch_q <= latch_now;
                        // The countdown reaches zero on this edge or was already there.
                        if (tick && (tl_zero || (tl_count == 11'd1))) begin
                            time_up_q <= 1'b1;
                        end
                    end
                end
                LEVEL_CLEAR: begin
                    if (clear_done) begin
                        finished_q <= '0;
                        level_q    <= (level_q == 3'd7) ? 3'd7 : level_q + 1'b1;
                        state_q    <= PLAY;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign FrogFinished = finished_q;
    assign lives        = lives_q;
    assign score        = score_q;
    assign level        = level_q;
    assign time_left    = tl_count;
    assign time_up      = time_up_q;
    assign game_active  = game_active_q;
    assign game_over    = (state_q == GAME_OVER);
    assign state        = state_q;

endmodule

// File: tb/tb_frog_game_ctrl.sv
// tb/tb_frog_game_ctrl.sv - directed self-checking bench for frog_game_ctrl
module tb_frog_game_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_clk_rising_edge;
    logic [7:0]  keycode;
    logic        is_dead_delayed;
    logic        ReachedFinish;
    logic [4:0]  OnFinish;
    logic [4:0]  FrogFinished;
    logic [2:0]  lives;
    logic [13:0] score;
    logic [2:0]  level;
    logic [10:0] time_left;
    logic        time_up;
    logic        game_active;
    logic        game_over;
    logic [2:0]  state;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_score;
    int exp_level;

    frog_game_ctrl dut (
        .Clk                   (Clk),
        .Reset_n               (Reset_n),
        .frame_clk_rising_edge (frame_clk_rising_edge),
        .keycode               (keycode),
        .is_dead_delayed       (is_dead_delayed),
        .ReachedFinish         (ReachedFinish),
        .OnFinish              (OnFinish),
        .FrogFinished          (FrogFinished),
        .lives                 (lives),
        .score                 (score),
        .level                 (level),
        .time_left             (time_left),
        .time_up               (time_up),
        .game_active           (game_active),
        .game_over             (game_over),
        .state                 (state)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(negedge Clk);
    endtask

    task automatic frame_edge();
        frame_clk_rising_edge = 1'b1;
        @(negedge Clk);
        frame_clk_rising_edge = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame_edge();
    endtask

    task automatic finish_slot(input int s);
        ReachedFinish = 1'b1;
        OnFinish      = 5'(1 << s);
        clk1();
        frame_edge();
        ReachedFinish = 1'b0;
        OnFinish      = 5'b0;
    endtask

    initial begin
        Reset_n = 1'b0;
        frame_clk_rising_edge = 1'b0;
        keycode = 8'h00;
        is_dead_delayed = 1'b0;
        ReachedFinish = 1'b0;
        OnFinish = 5'b0;
        repeat (3) clk1();

        chk("rst_state", state, 0);
        chk("rst_lives", lives, 0);
        chk("rst_time_left", time_left, 0);
        chk("rst_game_active", game_active, 0);
        chk("rst_game_over", game_over, 0);
        Reset_n = 1'b1;
        clk1();

        // Start a game
        keycode = 8'h28;
        clk1();
        chk("start_state", state, 1);
        chk("start_active_lag", game_active, 0);
        chk("start_lives", lives, 3);
        chk("start_time_left", time_left, 1800);
        clk1();
        chk("start_active", game_active, 1);
        keycode = 8'h00;

        // Finish in slot 2 with 1600 frames left: 50 + 100
        frames(200);
        chk("tl_1600", time_left, 1600);
        ReachedFinish = 1'b1;
        OnFinish = 5'b00100;
        repeat (3) clk1();
        frame_edge();
        ReachedFinish = 1'b0;
        OnFinish = 5'b0;
        chk("fin2_slots", FrogFinished, 5'b00100);
        chk("fin2_score", score, 150);
        chk("fin2_time_left", time_left, 1800);

        frames(200);
        finish_slot(0);
        chk("fin0_score", score, 300);
        chk("fin0_slots", FrogFinished, 5'b00101);

        // Asynchronous reset mid-PLAY
        #2 Reset_n = 1'b0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_score", score, 0);
        chk("arst_slots", FrogFinished, 0);
        chk("arst_lives", lives, 0);
        chk("arst_time_left", time_left, 0);
        chk("arst_active", game_active, 0);
        clk1();
        Reset_n = 1'b1;
        clk1();
        keycode = 8'h28;
        clk1();
        chk("restart_state", state, 1);
        chk("restart_lives", lives, 3);
        chk("restart_score", score, 0);
        keycode = 8'h00;
        clk1();

        // Fill all slots at full time: 162 each, last adds 1000
        for (int s = 0; s < 4; s++) finish_slot(s);
        chk("four_slots", FrogFinished, 5'b01111);
        chk("four_score", score, 648);
        finish_slot(4);
        chk("all_slots", FrogFinished, 5'b11111);
        chk("all_score", score, 1810);
        chk("clear_state", state, 2);
        frames(119);
        chk("hold119_state", state, 2);
        chk("hold119_slots", FrogFinished, 5'b11111);
        frame_edge();
        chk("hold120_state", state, 1);
        chk("hold120_slots", FrogFinished, 0);
        chk("hold120_level", level, 1);
        chk("hold120_time_left", time_left, 1800);

        // Timer expiry then death
        frames(1799);
        chk("tl_1", time_left, 1);
        chk("tu_early", time_up, 0);
        frame_edge();
        chk("tl_0", time_left, 0);
        chk("tu_set", time_up, 1);
        frame_edge();
        chk("tl_0_hold", time_left, 0);
        chk("tu_hold", time_up, 1);
        is_dead_delayed = 1'b1;
        frame_edge();
        is_dead_delayed = 1'b0;
        chk("death_lives", lives, 2);
        chk("death_tu", time_up, 0);
        chk("death_time_left", time_left, 1800);

        // Level loop: score saturation and level saturation at 7
        exp_score = 1810;
        exp_level = 1;
        for (int lv = 0; lv < 7; lv++) begin
            for (int s = 0; s < 5; s++) finish_slot(s);
            frames(120);
            exp_score = (exp_score + 1810 > 9999) ? 9999 : exp_score + 1810;
            exp_level = (exp_level == 7) ? 7 : exp_level + 1;
            chk("loop_score", score, exp_score);
            chk("loop_level", level, exp_level);
            chk("loop_state", state, 1);
        end
        chk("sat_score", score, 9999);
        chk("sat_level", level, 7);

        // Finish with zero time left while saturated
        frames(1800);
        chk("tl0_again", time_left, 0);
        finish_slot(2);
        chk("sat_fin_score", score, 9999);
        chk("sat_fin_slots", FrogFinished, 5'b00100);
        chk("sat_fin_tl", time_left, 1800);

        // Start key in PLAY is ignored
        keycode = 8'h28;
        clk1();
        chk("play_key_ignored", state, 1);
        is_dead_delayed = 1'b1;
        frame_edge();
        is_dead_delayed = 1'b0;
        chk("lives_1", lives, 1);

        // Simultaneous death and finish on last life
        is_dead_delayed = 1'b1;
        ReachedFinish = 1'b1;
        OnFinish = 5'b00010;
        clk1();
        frame_edge();
        is_dead_delayed = 1'b0;
        ReachedFinish = 1'b0;
        OnFinish = 5'b0;
        chk("go_lives", lives, 0);
        chk("go_state", state, 3);
        chk("go_flag", game_over, 1);
        chk("go_slots", FrogFinished, 5'b00100);
        clk1();
        chk("go_active", game_active, 0);
        frames(3);
        chk("go_frozen_tl", time_left, 1800);
        chk("go_held_key", state, 3);
        chk("go_frozen_score", score, 9999);

        keycode = 8'h00;
        clk1();
        keycode = 8'h28;
        clk1();
        chk("replay_state", state, 1);
        chk("replay_score", score, 0);
        chk("replay_lives", lives, 3);
        chk("replay_level", level, 0);
        chk("replay_slots", FrogFinished, 0);
        keycode = 8'h00;
        clk1();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
